// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg: definitions shared by the 10-bit link transmit path,
// the 8b/10b encoder and the receiver's comma detection.
package paralelo_serial_pkg;

  // Default word width of the link.
  localparam int CANTIDAD_BITS_DEF = 10;

  // K28.5 (RD-) in transmit order, bit 0 first on the line.
  localparam logic [9:0] K28_5_RDN = 10'h17C;

  // Transmitter control states.
  typedef enum logic {
    REPOSO    = 1'b0,
    TRANSMITE = 1'b1
  } estado_t;

endpackage

// File: rtl/paralelo_serial.sv
// paralelo_serial: parallel-to-serial converter for the 10-bit link.
// Takes one word per valido/listo handshake and shifts it out LSB first.
// Optional feature macro: PARALELO_SERIAL_COMMA_EN -- when defined, the idle
// line carries back-to-back IDLE_WORD frames and data only starts on a frame
// boundary; when undefined, the idle line is constant 0.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int                      cantidadBits = CANTIDAD_BITS_DEF,
  parameter logic [cantidadBits-1:0] IDLE_WORD    = cantidadBits'(K28_5_RDN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [cantidadBits-1:0] entradas,
  input  logic                    valido,
  output logic                    listo,
  output logic                    salida,
  output logic                    inicioPalabra,
  output logic                    ocupado
);

  localparam int              CW     = $clog2(cantidadBits);
  localparam logic [CW-1:0]   ULTIMO = CW'(cantidadBits - 1);
  localparam logic [CW-1:0]   UNO    = CW'(1);

  estado_t                 r_estado;
  logic [CW-1:0]           r_contador;
  logic [cantidadBits-1:0] r_registro;
  logic                    r_inicio;
  logic                    r_ocupado;

  estado_t                 w_nxt_estado;
  logic [CW-1:0]           w_nxt_contador;
  logic [cantidadBits-1:0] w_nxt_registro;
  logic [cantidadBits-1:0] w_desplazado;
  logic                    w_nxt_inicio;
  logic                    w_ultimo;
  logic                    w_acepta;

  assign w_ultimo     = (r_contador == ULTIMO);
  assign w_acepta     = valido && listo;
  assign w_desplazado = {1'b0, r_registro[cantidadBits-1:1]};

`ifdef PARALELO_SERIAL_COMMA_EN
  // Set by reset so the first idle frame starts on the first edge after release.
  logic r_primero;

  // Marks the pending start of the first idle frame after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_primero <= 1'b1;
    else       r_primero <= 1'b0;
  end

  // Data may only start where a frame (idle or data) ends.
  assign listo = !reset && w_ultimo;
`else
  // IDLE_WORD only matters for the comma-idle build.
  logic w_unused_idle;
  assign w_unused_idle = ^IDLE_WORD;

  // Ready whenever idle, or on the last bit of the current word.
  assign listo = !reset && ((r_estado == REPOSO) || w_ultimo);
`endif

  // Next-state, counter and shift-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_nxt_estado   = r_estado;
    w_nxt_contador = r_contador;
    w_nxt_registro = r_registro;
    unique case (r_estado)
      REPOSO: begin
`ifdef PARALELO_SERIAL_COMMA_EN
        if (r_primero) begin
          w_nxt_registro = IDLE_WORD;
          w_nxt_contador = '0;
        end else if (w_acepta) begin
          w_nxt_registro = entradas;
          w_nxt_contador = '0;
          w_nxt_estado   = TRANSMITE;
        end else if (w_ultimo) begin
          w_nxt_registro = IDLE_WORD;
          w_nxt_contador = '0;
        end else begin
          w_nxt_registro = w_desplazado;
          w_nxt_contador = r_contador + UNO;
        end
`else
        if (w_acepta) begin
          w_nxt_registro = entradas;
          w_nxt_contador = '0;
          w_nxt_estado   = TRANSMITE;
        end
`endif
      end
      TRANSMITE: begin
        if (w_ultimo) begin
          w_nxt_contador = '0;
          if (w_acepta) begin
            w_nxt_registro = entradas;
          end else begin
            w_nxt_estado   = REPOSO;
`ifdef PARALELO_SERIAL_COMMA_EN
            w_nxt_registro = IDLE_WORD;
`else
            w_nxt_registro = '0;
`endif
          end
        end else begin
          w_nxt_registro = w_desplazado;
          w_nxt_contador = r_contador + UNO;
        end
      end
      default: w_nxt_estado = REPOSO;
    endcase
  end

  // Frame-start flag for the bit that will be on the line after this edge.
`ifdef PARALELO_SERIAL_COMMA_EN
  assign w_nxt_inicio = (w_nxt_contador == '0);
`else
  assign w_nxt_inicio = (w_nxt_estado == TRANSMITE) && (w_nxt_contador == '0);
`endif

  // State, counter, shift register and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is reset too because salida is taken
      // straight from its bit 0; a stale word must not reach the line.
      r_estado   <= REPOSO;
      r_contador <= '0;
      r_registro <= '0;
      r_inicio   <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_estado   <= w_nxt_estado;
      r_contador <= w_nxt_contador;
      r_registro <= w_nxt_registro;
      r_inicio   <= w_nxt_inicio;
      r_ocupado  <= (w_nxt_estado == TRANSMITE);
    end
  end

  assign salida        = r_registro[0];
  assign inicioPalabra = r_inicio;
  assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: self-checking bench for paralelo_serial.
// Reference model: a queue of the bits still to appear on the line; a word
// accepted at an edge appends all its bits, each edge consumes one bit.
// Follows PARALELO_SERIAL_COMMA_EN when the bundle is built with it.
module tb_paralelo_serial;

  localparam int N = 10;
  localparam logic [N-1:0] IDLE = 10'h17C;

  typedef struct packed {
    logic b;  // line bit
    logic s;  // first bit of a frame
    logic d;  // belongs to a data word
  } bit_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] entradas;
  logic         valido;
  logic         listo;
  logic         salida;
  logic         inicioPalabra;
  logic         ocupado;

  bit_t         linea[$];
  logic [N-1:0] enviados[$];
  int           total = 0;
  int           bad = 0;

  logic [N-1:0] rx_w;
  int           rx_cnt;
  logic         rx_act;
  logic         rx_dat;

  paralelo_serial #(.cantidadBits(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .entradas     (entradas),
    .valido       (valido),
    .listo        (listo),
    .salida       (salida),
    .inicioPalabra(inicioPalabra),
    .ocupado      (ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_listo();
    if (reset) return 1'b0;
`ifdef PARALELO_SERIAL_COMMA_EN
    return linea.size() == 1;
`else
    return linea.size() <= 1;
`endif
  endfunction

  task automatic avanzar(input logic acc, input logic [N-1:0] w);
    if (linea.size() > 0) void'(linea.pop_front());
    if (acc) begin
      for (int i = 0; i < N; i++) linea.push_back('{b: w[i], s: (i == 0), d: 1'b1});
    end
`ifdef PARALELO_SERIAL_COMMA_EN
    else if (linea.size() == 0) begin
      for (int i = 0; i < N; i++) linea.push_back('{b: IDLE[i], s: (i == 0), d: 1'b0});
    end
`endif
  endtask

  task automatic comparar();
    bit_t e;
    e = (linea.size() > 0) ? linea[0] : '0;
    check("salida", salida, e.b);
    check("inicio", inicioPalabra, e.s);
    check("ocupado", ocupado, e.d);
    check("listo", listo, m_listo());
  endtask

  // Independent receiver: reassembles words aligned on inicioPalabra.
  task automatic receptor();
    if (inicioPalabra) begin
      rx_act = 1'b1;
      rx_cnt = 0;
      rx_dat = ocupado;
    end
    if (rx_act) begin
      rx_w[rx_cnt] = salida;
      rx_cnt++;
      if (rx_cnt == N) begin
        rx_act = 1'b0;
        if (rx_dat) begin
          if (enviados.size() == 0) check("rx_extra", 1, 0);
          else check("rx_palabra", rx_w, enviados.pop_front());
        end
      end
    end
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic ciclo();
    logic         acc;
    logic [N-1:0] w;
    acc = valido && m_listo();
    w   = entradas;
    if (acc) enviados.push_back(w);
    @(posedge clk);
    avanzar(acc, w);
    @(negedge clk);
    comparar();
    receptor();
  endtask

  task automatic send(input logic [N-1:0] w);
    int k;
    bit hecho;
    k = 0;
    hecho = 1'b0;
    valido = 1'b1;
    entradas = w;
    while (!hecho && k < 64) begin
      hecho = m_listo();
      ciclo();
      k++;
    end
    if (!hecho) check("send_timeout", 0, 1);
    valido = 1'b0;
    entradas = N'($urandom);
  endtask

  // Asynchronous reset between edges, released on the next falling edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_salida", salida, 0);
    check("rst_inicio", inicioPalabra, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_listo", listo, 0);
    linea.delete();
    enviados.delete();
    rx_act = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_listo", listo, m_listo());
  endtask

  initial begin
    reset    = 1'b1;
    valido   = 1'b0;
    entradas = '0;
    rx_act   = 1'b0;
    rx_cnt   = 0;
    rx_dat   = 1'b0;
    rx_w     = '0;
    @(negedge clk);
    @(negedge clk);
    check("ini_salida", salida, 0);
    check("ini_inicio", inicioPalabra, 0);
    check("ini_ocupado", ocupado, 0);
    check("ini_listo", listo, 0);
    reset = 1'b0;
    #1;
    comparar();

    // Single word.
    send(10'h2A5);
    repeat (N + 2) ciclo();

    // Back-to-back words with valido held.
    send(10'h3FF);
    send(10'h001);
    repeat (N + 2) ciclo();

    // Late valido: three idle cycles between words.
    send(10'h1C3);
    repeat (N - 1) ciclo();
    repeat (3) ciclo();
    send(10'h0F0);
    repeat (N + 2) ciclo();

    // Loopback sequence.
    send(10'h155);
    send(10'h0AA);
    send(10'h17C);
    repeat (N + 2) ciclo();

    // Long idle stretch.
    repeat (30) ciclo();

    // Reset while bit 4 of a word is on the line.
    send(10'h2A5);
    repeat (4) ciclo();
    do_reset();
    repeat (N + 3) ciclo();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      valido   = ($urandom_range(2) != 0);
      entradas = N'($urandom);
      if ($urandom_range(199) == 0) do_reset();
      else ciclo();
    end

    valido = 1'b0;
    repeat (2 * N + 2) ciclo();
    check("rx_pendientes", enviados.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Parallel-to-serial converter for the 10-bit link: accepts one word per valid/ready handshake and shifts it out one bit per clock, bit 0 first, so the existing serial-to-parallel receiver reconstructs the word unchanged. Sits on the transmit side of the link, between the word source (8b/10b encoder output) and the serial line.

## Interface
- `cantidadBits`, default 10: word width; must be ≥ 2.
- `IDLE_WORD`, default 10'h17C: K28.5 (RD−) in transmit order, bit 0 first. Used only with `PARALELO_SERIAL_COMMA_EN`.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `entradas` input, `cantidadBits` bits: word to transmit; sampled only on an accepting edge.
- `valido` input, 1 bit: source has a word on `entradas`.
- `listo` output, 1 bit: block accepts a word on this edge if `valido` is high.
- `salida` output, 1 bit: serial data.
- `inicioPalabra` output, 1 bit: high while bit 0 of any frame is on `salida`.
- `ocupado` output, 1 bit: high while a data word, not idle, is being shifted.

## Operation
- State: FSM {`REPOSO`, `TRANSMITE`}, shift register `registro[cantidadBits-1:0]`, bit counter `contador` of width clog2(cantidadBits).
- Accept: `valido && listo` at a rising edge. `registro` ← `entradas`, `contador` ← 0, state → `TRANSMITE`.
- `TRANSMITE`: `salida` = `registro[0]`. Each edge shifts `registro` right by one and increments `contador`.
- `contador == cantidadBits-1`, last bit: `listo` high. On accept, the next word loads back-to-back with no gap. Otherwise, state → `REPOSO` and `contador` wraps to 0.
- `REPOSO` without the macro: `salida` = 0, `listo` = 1, `inicioPalabra` = 0, `ocupado` = 0.
- `listo` is combinational from state, counter and reset. It is forced to 0 while `reset` is high.
- `entradas` changing mid-word has no effect.
- `valido` is never required to stay high. A source that drops `valido` before acceptance loses nothing.
- Reset, asynchronous and possibly mid-word: state `REPOSO`, `contador` 0, `registro` 0, `salida` 0, `inicioPalabra` 0, `ocupado` 0. The partial word is discarded.

## Timing
- Latency: a word accepted at edge T puts bit 0 on `salida` after T. Bit k is present between edges T+k and T+k+1.
- All outputs except `listo` are registered.
- Throughput: one word per `cantidadBits` cycles with `valido` held high.
- `inicioPalabra` is high exactly in cycles where `contador == 0` in `TRANSMITE`, or during an idle frame when the macro is enabled.

## Configuration
- `PARALELO_SERIAL_COMMA_EN` defined:
  - In `REPOSO`, the block continuously transmits `IDLE_WORD` frames with the same counter and shift path. `ocupado` = 0 and `inicioPalabra` marks each idle frame start.
  - `listo` is high only when `contador == cantidadBits-1`, so data always starts on a frame boundary.
  - After reset, the first idle frame starts on the first edge after `reset` falls.
- Undefined: idle line is constant 0 and `listo` is high throughout `REPOSO`.

## Structure
- Shared package `paralelo_serial_pkg` holds:
  - the state enum (`REPOSO`, `TRANSMITE`);
  - the K28.5 constant, shared with the encoder and the receiver's comma detection;
  - the default width constant.
- No sub-module. FSM, counter and shift register live in one module.

## Test plan
- Reset mid-word: assert `reset` while bit 4 of 10'h2A5 is on `salida` → all outputs 0 immediately; `listo` = 1 on the first edge after release, macro off.
- Single word: send 10'h2A5 at edge T → `salida` reads 1,0,1,0,0,1,0,1,0,1 on cycles T..T+9; `inicioPalabra` high only in cycle T; back to 0 at T+10.
- Back-to-back: `valido` held high with 10'h3FF then 10'h001 → 20 contiguous bits with no gap; `listo` high exactly at cycles T+9 and T+19.
- Loopback: feed `salida` into the serial-to-parallel receiver, aligned by `inicioPalabra` → receiver outputs 10'h155, 10'h0AA, 10'h17C in order.
- Late `valido`: assert `valido` 3 cycles after the previous word ends → idle zeros for 3 cycles, then the word starts the cycle after acceptance.
- Macro on: no `valido` for 30 cycles → `salida` repeats 0,0,1,1,1,1,1,0,1,0 three times; a word offered mid-frame waits for `contador == 9`, then starts on the frame boundary.
